// File: rtl/hexa_display_scan_pkg.sv
// Shared constants for the hex display scanner: segment codes, blank and
// anode-off patterns, and the digit index encoding.
package hexa_display_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    DIG_UNIDAD  = 2'd0,
    DIG_DECENA  = 2'd1,
    DIG_CENTENA = 2'd2
  } digit_e;

  function automatic logic [3:0] anode_pattern(input digit_e dig);
    logic [3:0] pat;
    pat = ANODE_OFF;
    case (dig)
      DIG_UNIDAD:  pat = 4'b1110;
      DIG_DECENA:  pat = 4'b1101;
      DIG_CENTENA: pat = 4'b1011;
      default:     pat = ANODE_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/hexa_display_scan_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hexa_a_7seg
  import hexa_display_scan_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] segmentos
);

  always_comb begin
    segmentos = SEG_TABLE[digito];
  end

endmodule

// File: rtl/hexa_display_scan.sv
// Multiplexed three-digit hex display scanner with double-buffered value,
// frame-aligned updates and optional leading-zero blanking.
module hexa_display_scan
  import hexa_display_scan_pkg::*;
#(
  parameter int unsigned DIV_REFRESCO = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dato,
  input  logic       cargar,
  input  logic       blanco_ceros,
  output logic [3:0] anodos,
  output logic [6:0] segmentos,
  output logic       actualizado
);

  localparam int unsigned CNT_W = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_REFRESCO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_e           idx_q, idx_d;
  logic [7:0]       valor_q, valor_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             act_q, act_d;
  logic [3:0]       anodos_q, anodos_d;
  logic [6:0]       seg_q, seg_d;

  logic       tick;
  logic       frontera;
  logic [3:0] centena, decena, unidad;
  logic [3:0] digito_sel;
  logic       blanco_sel;
  logic [6:0] seg_raw;

  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    frontera = tick && (idx_q == DIG_CENTENA);
  end

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      case (idx_q)
        DIG_UNIDAD:  idx_d = DIG_DECENA;
        DIG_DECENA:  idx_d = DIG_CENTENA;
        default:     idx_d = DIG_UNIDAD;
      endcase
    end
  end

  // The boundary transfer uses the old pend; a coincident cargar refills it
  // and keeps pend_v set for the following frame.
  always_comb begin
    valor_d  = valor_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    act_d    = frontera && pend_v_q;
    if (frontera && pend_v_q) begin
      valor_d  = pend_q;
      pend_v_d = 1'b0;
    end
    if (cargar) begin
      pend_d   = dato;
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
    centena    = 4'h0;
    decena     = valor_q[7:4];
    unidad     = valor_q[3:0];
    digito_sel = unidad;
    blanco_sel = 1'b0;
    case (idx_q)
      DIG_DECENA: begin
        digito_sel = decena;
        blanco_sel = blanco_ceros && (centena == 4'h0) && (decena == 4'h0);
      end
      DIG_CENTENA: begin
        digito_sel = centena;
        blanco_sel = blanco_ceros && (centena == 4'h0);
      end
      default: begin
        digito_sel = unidad;
        blanco_sel = 1'b0;
      end
    endcase
  end

  hexa_a_7seg u_dec (
    .digito    (digito_sel),
    .segmentos (seg_raw)
  );

  always_comb begin
    anodos_d = anode_pattern(idx_q);
    seg_d    = blanco_sel ? SEG_BLANK : seg_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= DIG_UNIDAD;
      valor_q  <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      act_q    <= 1'b0;
      anodos_q <= ANODE_OFF;
      seg_q    <= SEG_BLANK;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      valor_q  <= valor_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      act_q    <= act_d;
      anodos_q <= anodos_d;
      seg_q    <= seg_d;
    end
  end

  assign anodos      = anodos_q;
  assign segmentos   = seg_q;
  assign actualizado = act_q;

endmodule

// File: tb/tb_hexa_display_scan.sv
// Randomized and directed bench for hexa_display_scan against a cycle-level
// behavioural model of the scanner.
module tb_hexa_display_scan;

  localparam int DIV = 4;
  localparam int FRAME = 3 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dato;
  logic       cargar;
  logic       blanco_ceros;
  logic [3:0] anodos;
  logic [6:0] segmentos;
  logic       actualizado;

  hexa_display_scan #(.DIV_REFRESCO(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .dato         (dato),
    .cargar       (cargar),
    .blanco_ceros (blanco_ceros),
    .anodos       (anodos),
    .segmentos    (segmentos),
    .actualizado  (actualizado)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_ref [16];
  int n_checks = 0;
  int n_fail   = 0;
  int act_seen = 0;

  // model state: cycles since reset release, digit, shown value, buffer
  int m_n, m_idx, m_valor, m_pend, m_pendv;
  int m_an, m_seg, m_act;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int digit_seg(input int idx, input int valor, input int b);
    int cen, dec, uni;
    cen = valor / 256;
    dec = (valor % 256) / 16;
    uni = valor % 16;
    if (idx == 2) return (b != 0 && cen == 0) ? 7'h7F : int'(seg_ref[cen]);
    if (idx == 1) return (b != 0 && cen == 0 && dec == 0) ? 7'h7F : int'(seg_ref[dec]);
    return int'(seg_ref[uni]);
  endfunction

  task automatic model_step(input logic r, input logic c, input logic [7:0] d, input logic b);
    int tick, bnd;
    if (r) begin
      m_n = 0; m_idx = 0; m_valor = 0; m_pend = 0; m_pendv = 0;
      m_an = 4'hF; m_seg = 7'h7F; m_act = 0;
      return;
    end
    m_an  = 4'hF & ~(1 << m_idx);
    m_seg = digit_seg(m_idx, m_valor, int'(b));
    tick  = ((m_n % DIV) == DIV - 1) ? 1 : 0;
    bnd   = (tick != 0 && m_idx == 2) ? 1 : 0;
    m_act = (bnd != 0 && m_pendv != 0) ? 1 : 0;
    if (m_act != 0) begin
      m_valor = m_pend;
      m_pendv = 0;
    end
    if (c) begin
      m_pend  = int'(d);
      m_pendv = 1;
    end
    if (tick != 0) m_idx = (m_idx + 1) % 3;
    m_n++;
  endtask

  task automatic cycle(input logic r, input logic c, input logic [7:0] d, input logic b);
    reset = r; cargar = c; dato = d; blanco_ceros = b;
    @(posedge clk);
    model_step(r, c, d, b);
    #1;
    check_val("anodos", 32'(anodos), 32'(m_an));
    check_val("segmentos", 32'(segmentos), 32'(m_seg));
    check_val("actualizado", 32'(actualizado), 32'(m_act));
    if (actualizado === 1'b1) act_seen++;
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, b);
  endtask

  // advance until the next cycle is a frame boundary (model-side position)
  task automatic to_boundary(input logic b);
    int guard;
    guard = 0;
    while (!((m_n % DIV) == DIV - 1 && m_idx == 2) && guard < 4 * FRAME) begin
      cycle(1'b0, 1'b0, 8'h00, b);
      guard++;
    end
    check_val("boundary_wait", 32'(guard < 4 * FRAME), 32'd1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset = 1'b1; cargar = 1'b0; dato = '0; blanco_ceros = 1'b0;

    // reset values, then first displayed digit
    do_reset(3);
    check_val("reset_anodos", 32'(anodos), 32'h0F);
    check_val("reset_seg", 32'(segmentos), 32'h7F);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_val("first_anodos", 32'(anodos), 32'b1110);
    check_val("first_seg", 32'(segmentos), 32'b1000000);

    // idle scan: no update pulses
    act_seen = 0;
    idle(3 * FRAME, 1'b0);
    check_val("idle_pulses", 32'(act_seen), 32'd0);

    // mid-frame load of A7
    act_seen = 0;
    to_boundary(1'b0);
    idle(5, 1'b0);
    cycle(1'b0, 1'b1, 8'hA7, 1'b0);
    idle(2 * FRAME, 1'b0);
    check_val("a7_pulses", 32'(act_seen), 32'd1);
    check_val("a7_valor", 32'(dut.valor_q), 32'hA7);

    // last load wins
    act_seen = 0;
    to_boundary(1'b0);
    idle(2, 1'b0);
    cycle(1'b0, 1'b1, 8'h12, 1'b0);
    idle(3, 1'b0);
    cycle(1'b0, 1'b1, 8'h3F, 1'b0);
    idle(2 * FRAME, 1'b0);
    check_val("last_wins_pulses", 32'(act_seen), 32'd1);

    // load on the boundary cycle while 22 is pending
    act_seen = 0;
    to_boundary(1'b0);
    idle(4, 1'b0);
    cycle(1'b0, 1'b1, 8'h22, 1'b0);
    to_boundary(1'b0);
    cycle(1'b0, 1'b1, 8'h55, 1'b0);
    idle(FRAME - 1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    idle(FRAME, 1'b0);
    check_val("coincide_pulses", 32'(act_seen), 32'd2);

    // leading-zero blanking with 05 and 00
    cycle(1'b0, 1'b1, 8'h05, 1'b1);
    idle(3 * FRAME, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    idle(3 * FRAME, 1'b1);

    // reset with a pending value discards it
    to_boundary(1'b0);
    idle(2, 1'b0);
    cycle(1'b0, 1'b1, 8'h9C, 1'b0);
    do_reset(2);
    check_val("rst_pend_anodos", 32'(anodos), 32'h0F);
    check_val("rst_pend_seg", 32'(segmentos), 32'h7F);
    act_seen = 0;
    idle(3 * FRAME, 1'b0);
    check_val("rst_pend_pulses", 32'(act_seen), 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic r, c, b;
      logic [7:0] d;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 15) == 0);
      b = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = {4'h0, d[3:0]};
      cycle(r, c, d, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
